wb_scoreboard: RTL

//  Register-write scoreboard for the 5-stage pipeline. Tracks in-flight writes to the register

---
 rtl/wb_scoreboard_if.sv | 31 +++
 rtl/wb_scoreboard.sv | 74 +++++++
 2 files changed

// File: rtl/wb_scoreboard_if.sv
// wb_scoreboard_if: decode/writeback/control bundle between pipeline and register-write scoreboard
interface wb_scoreboard_if #(
  parameter int REG_W    = 3,
  parameter int NUM_REGS = 8
);
  logic                issue_valid;
  logic                issue_wr_en;
  logic [REG_W-1:0]    issue_dst;
  logic                src1_valid;
  logic [REG_W-1:0]    src1;
  logic                src2_valid;
  logic [REG_W-1:0]    src2;
  logic                retire_valid;
  logic [REG_W-1:0]    retire_reg;
  logic                flush;
  logic                drain_req;
  logic                stall;
  logic                drain_done;
  logic [NUM_REGS-1:0] pending;
  logic                err;
  modport master (
    output issue_valid, issue_wr_en, issue_dst, src1_valid, src1, src2_valid, src2,
           retire_valid, retire_reg, flush, drain_req,
    input  stall, drain_done, pending, err
  );
  modport slave (
    input  issue_valid, issue_wr_en, issue_dst, src1_valid, src1, src2_valid, src2,
           retire_valid, retire_reg, flush, drain_req,
    output stall, drain_done, pending, err
  );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write counters with RAW/saturation stall and flush/drain FSM
// Define WB_SCOREBOARD_BYPASS_EN to let a same-cycle final retire satisfy a source hazard.
module wb_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 2
) (
  input logic clk,
  input logic rst,
  wb_scoreboard_if.slave bus_io
);
`ifdef WB_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_e;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                err_q, err_d, dd_q;
  logic                haz1, haz2, sat, stall, accept, all_zero;
  logic                rv;
  logic [REG_W-1:0]    rr;
  assign rv = bus_io.retire_valid;
  assign rr = bus_io.retire_reg;
  // A retire that empties the counter this cycle is visible through the regfile bypass
  assign haz1 = bus_io.src1_valid && cnt_q[bus_io.src1] != '0 &&
                !(BYP && rv && rr == bus_io.src1 && cnt_q[bus_io.src1] == CNT_ONE);
  assign haz2 = bus_io.src2_valid && cnt_q[bus_io.src2] != '0 &&
                !(BYP && rv && rr == bus_io.src2 && cnt_q[bus_io.src2] == CNT_ONE);
  assign sat = bus_io.issue_wr_en && cnt_q[bus_io.issue_dst] == CNT_MAX &&
               !(rv && rr == bus_io.issue_dst);
  assign stall  = state_q != RUN || (bus_io.issue_valid && (haz1 || haz2 || sat));
  assign accept = bus_io.issue_valid && !stall;
  always_comb begin
    all_zero = 1'b1;
    pend_d   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = bus_io.flush ? '0 :
                 (accept && bus_io.issue_wr_en && bus_io.issue_dst == REG_W'(i)) ?
                   ((rv && rr == REG_W'(i)) ? cnt_q[i] : cnt_q[i] + CNT_ONE) :
                 (rv && rr == REG_W'(i) && cnt_q[i] != '0) ? cnt_q[i] - CNT_ONE : cnt_q[i];
      pend_d[i] = cnt_d[i] != '0;
      all_zero  = all_zero && cnt_d[i] == '0;
    end
    err_d   = err_q || (!bus_io.flush && rv && cnt_q[rr] == '0);
    state_d = state_q == RUN   ? (bus_io.drain_req ? DRAIN : RUN) :
              state_q == DRAIN ? (all_zero ? DONE : DRAIN) :
              (bus_io.drain_req ? HOLD : RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '{default: '0};
      state_q <= RUN;
      pend_q  <= '0;
      err_q   <= 1'b0;
      dd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      dd_q    <= state_d == DONE;
    end
  end
  assign bus_io.stall      = stall;
  assign bus_io.pending    = pend_q;
  assign bus_io.err        = err_q;
  assign bus_io.drain_done = dd_q;
endmodule
